sw_debounce: RTL and testbench

- Switch conditioning stage directly upstream of the rate counter.
- Takes the raw board slide switches, synchronises each bit into the clock domain, and filters contact bounce.
- Drives a clean, stable switch vector to the counter's speed-select input and to the LED colour-select bit.
- Also emits one-cycle rise/fall pulses per bit for any logic that needs edge events.

---
 rtl/led_pkg.sv | 18 +
 rtl/sw_debounce_bit.sv | 73 +++++++
 rtl/sw_debounce.sv | 41 ++++
 tb/tb_sw_debounce.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the switch conditioning and LED/counter datapath.
// The hardware defaults give a 10 ms settle window at 100 MHz. The
// simulation override keeps test runs short.
package led_pkg;

  // Number of board slide switches.
  localparam int NB_SW        = 4;

  // Width of each per-bit stability counter.
  localparam int NB_STABLE    = 20;

  // Consecutive cycles a level must persist: 10 ms at 100 MHz.
  localparam int N_STABLE     = 1000000;

  // Short settle window used when simulating.
  localparam int N_STABLE_SIM = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit switch conditioner.
// The raw level passes through a 2-FF synchroniser. The synchronised level
// must then differ from the accepted level for N_STABLE consecutive cycles
// before it is accepted. On acceptance, a one-cycle rise or fall pulse is
// registered on the same edge that updates the level.
module sw_debounce_bit
  import led_pkg::*;
#(
  parameter int NB_STABLE = led_pkg::NB_STABLE,
  parameter int N_STABLE  = led_pkg::N_STABLE
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall
);

  // Terminal count. N_STABLE can be as large as 2^NB_STABLE, so the last
  // count value still fits in NB_STABLE bits.
  localparam logic [NB_STABLE-1:0] LP_LAST = NB_STABLE'(N_STABLE - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic [NB_STABLE-1:0] r_cnt;
  logic                 r_sw;
  logic                 r_rise;
  logic                 r_fall;
  logic                 w_differ;

  assign w_differ = (r_sync2 != r_sw);

  // Bring the asynchronous switch level into the clock domain.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles of disagreement, then accept the new level
  // and emit a single-cycle edge pulse on the same edge.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_sw   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_cnt  <= '0;
        r_sw   <= r_sync2;
        r_rise <= r_sync2;
        r_fall <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + NB_STABLE'(1);
      end
    end
  end

  assign o_sw   = r_sw;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning stage that feeds the rate counter and LED colour select.
// Each switch bit has its own independent synchroniser and bounce filter.
// This level only gathers the per-bit results into vectors.
module sw_debounce
  import led_pkg::*;
#(
  parameter int NB_SW     = led_pkg::NB_SW,
  parameter int NB_STABLE = led_pkg::NB_STABLE,
  parameter int N_STABLE  = led_pkg::N_STABLE
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_sw_rise,
  output logic [NB_SW-1:0] o_sw_fall
);

  logic [NB_SW-1:0] w_sw;
  logic [NB_SW-1:0] w_rise;
  logic [NB_SW-1:0] w_fall;

  for (genvar gi = 0; gi < NB_SW; gi++) begin : g_bit
    sw_debounce_bit #(
      .NB_STABLE (NB_STABLE),
      .N_STABLE  (N_STABLE)
    ) u_bit (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw[gi]),
      .o_sw    (w_sw[gi]),
      .o_rise  (w_rise[gi]),
      .o_fall  (w_fall[gi])
    );
  end

  assign o_sw      = w_sw;
  assign o_sw_rise = w_rise;
  assign o_sw_fall = w_fall;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a 4-cycle settle window.
// The stimulus drives inputs on the falling edge. Every expected edge pulse
// is queued together with the cycle it should appear on. A separate monitor
// pops one queued event whenever the DUT shows any pulse.
module tb_sw_debounce;

  // With N_STABLE=4, an input change made before posedge k+1 produces a
  // pulse visible after posedge k+6.
  localparam int LATENCY = 6;

  typedef struct {
    int         cycle;
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
  } expEvent_t;

  logic       clock;
  logic       resetN;
  logic [3:0] swIn;
  logic [3:0] swOut;
  logic [3:0] swRise;
  logic [3:0] swFall;

  int        cycleCnt    = 0;
  int        assertCount = 0;
  int        failCount   = 0;
  expEvent_t expQ[$];

  sw_debounce #(
    .NB_SW     (4),
    .NB_STABLE (3),
    .N_STABLE  (led_pkg::N_STABLE_SIM)
  ) dut (
    .clock     (clock),
    .i_reset   (resetN),
    .i_sw      (swIn),
    .o_sw      (swOut),
    .o_sw_rise (swRise),
    .o_sw_fall (swFall)
  );

  // 10 ns clock period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count rising edges so that expected pulse times can be stated in cycles.
  always @(posedge clock) begin
    cycleCnt = cycleCnt + 1;
  end

  // Monitor: every cycle that shows a pulse must match the oldest queued event.
  always @(negedge clock) begin
    if ((swRise | swFall) != 4'h0) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedPulse cycle=%0d rise=%h fall=%h required no pulse",
                 cycleCnt, swRise, swFall);
      end else begin
        expEvent_t ev;
        ev = expQ.pop_front();
        assertCount += 4;
        if (cycleCnt != ev.cycle) begin
          failCount++;
          $display("[TB] FAIL pulseCycle actual=%0d required=%0d", cycleCnt, ev.cycle);
        end
        if (swOut !== ev.sw) begin
          failCount++;
          $display("[TB] FAIL pulseSw actual=%h required=%h", swOut, ev.sw);
        end
        if (swRise !== ev.rise) begin
          failCount++;
          $display("[TB] FAIL pulseRise actual=%h required=%h", swRise, ev.rise);
        end
        if (swFall !== ev.fall) begin
          failCount++;
          $display("[TB] FAIL pulseFall actual=%h required=%h", swFall, ev.fall);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive a new switch vector and optionally queue the pulse it should cause.
  task automatic applyStimulus(input logic [3:0] newSw, input bit expectPulse,
                               input logic [3:0] expRise, input logic [3:0] expFall);
    expEvent_t ev;
    swIn = newSw;
    if (expectPulse) begin
      ev.cycle = cycleCnt + LATENCY;
      ev.sw    = newSw;
      ev.rise  = expRise;
      ev.fall  = expFall;
      expQ.push_back(ev);
    end
  endtask

  // Compare the settled outputs against constant expectations.
  task automatic checkOutput(input string name, input logic [3:0] expSw,
                             input logic [3:0] expRise, input logic [3:0] expFall);
    assertCount += 3;
    if (swOut !== expSw) begin
      failCount++;
      $display("[TB] FAIL %s.sw actual=%h required=%h", name, swOut, expSw);
    end
    if (swRise !== expRise) begin
      failCount++;
      $display("[TB] FAIL %s.rise actual=%h required=%h", name, swRise, expRise);
    end
    if (swFall !== expFall) begin
      failCount++;
      $display("[TB] FAIL %s.fall actual=%h required=%h", name, swFall, expFall);
    end
  endtask

  initial begin
    resetN = 1'b0;
    swIn   = 4'hF;
    waitCycles(3);
    $display("[TB] reset with switches high");
    checkOutput("resetHold", 4'h0, 4'h0, 4'h0);

    // Release reset: the full window is needed, then all four bits rise together.
    resetN = 1'b1;
    applyStimulus(4'hF, 1'b1, 4'hF, 4'h0);
    waitCycles(8);
    checkOutput("afterRelease", 4'hF, 4'h0, 4'h0);

    // Bring everything low, then make a clean rise on bit 0 only.
    $display("[TB] clean edge");
    applyStimulus(4'h0, 1'b1, 4'h0, 4'hF);
    waitCycles(8);
    checkOutput("allLow", 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h1, 1'b1, 4'h1, 4'h0);
    waitCycles(8);
    checkOutput("cleanEdge", 4'h1, 4'h0, 4'h0);

    // Toggle bit 1 every 2 cycles. It must never qualify until it holds high.
    $display("[TB] bounce");
    applyStimulus(4'h3, 1'b0, 4'h0, 4'h0);
    waitCycles(2);
    applyStimulus(4'h1, 1'b0, 4'h0, 4'h0);
    waitCycles(2);
    applyStimulus(4'h3, 1'b0, 4'h0, 4'h0);
    waitCycles(2);
    applyStimulus(4'h1, 1'b0, 4'h0, 4'h0);
    waitCycles(2);
    checkOutput("duringBounce", 4'h1, 4'h0, 4'h0);
    applyStimulus(4'h3, 1'b1, 4'h2, 4'h0);
    waitCycles(8);
    checkOutput("afterBounce", 4'h3, 4'h0, 4'h0);

    // Set bit 2, then drop it for 3 cycles. The count reaches N-1 but does not accept.
    $display("[TB] short glitch");
    applyStimulus(4'h7, 1'b1, 4'h4, 4'h0);
    waitCycles(8);
    applyStimulus(4'h3, 1'b0, 4'h0, 4'h0);
    waitCycles(3);
    applyStimulus(4'h7, 1'b0, 4'h0, 4'h0);
    waitCycles(8);
    checkOutput("afterGlitch", 4'h7, 4'h0, 4'h0);

    // Several bits change at once and must produce pulses in the same cycle.
    $display("[TB] simultaneous");
    applyStimulus(4'h0, 1'b1, 4'h0, 4'h7);
    waitCycles(8);
    applyStimulus(4'hA, 1'b1, 4'hA, 4'h0);
    waitCycles(8);
    applyStimulus(4'h5, 1'b1, 4'h5, 4'hA);
    waitCycles(8);
    checkOutput("simultaneous", 4'h5, 4'h0, 4'h0);

    // Raise bit 3 and reset after 2 counting cycles. The full window must repeat.
    $display("[TB] reset mid-count");
    applyStimulus(4'hD, 1'b0, 4'h0, 4'h0);
    waitCycles(4);
    resetN = 1'b0;
    waitCycles(2);
    checkOutput("midReset", 4'h0, 4'h0, 4'h0);
    resetN = 1'b1;
    applyStimulus(4'hD, 1'b1, 4'hD, 4'h0);
    waitCycles(5);
    checkOutput("beforeRequalify", 4'h0, 4'h0, 4'h0);
    waitCycles(3);
    checkOutput("afterRequalify", 4'hD, 4'h0, 4'h0);

    waitCycles(4);
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL pendingEvents actual=%0d required=0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
